// File: rtl/adc_upload_pkg.sv
// Shared definitions for the ADC frame uploader: FSM state encoding,
// frame sync bytes and the UART bit-period helper.
// ADC_UPLOAD_CKSUM_EN adds the checksum state to the encoding.
package adc_upload_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_FETCH,
        ST_WAIT,
        ST_SEND,
        ST_REARM
`ifdef ADC_UPLOAD_CKSUM_EN
        , ST_CKSUM
`endif
    } state_t;

    localparam logic [7:0] SYNC0 = 8'hA5;
    localparam logic [7:0] SYNC1 = 8'h5A;

    // Clocks per UART bit, rounded down.
    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter, LSB first, DIV clocks per bit.
// tx_busy falls two clocks before the stop bit ends so that a registered
// tx_start from the caller lands exactly on the stop-bit boundary; the
// next start bit then follows with no extra idle time.
module uart_tx_byte #(
    parameter int DIV = 16
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int             CW       = $clog2(DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]  CNT_PRE  = CW'(DIV - 2);

    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit;
    logic [8:0]    r_sh;
    logic          r_busy;
    logic          r_txd;
    logic          r_done;

    logic          w_last_bit;
    logic          w_end;
    logic          w_load;

    assign w_last_bit = (r_bit == 4'd9);
    assign w_end      = r_busy && w_last_bit && (r_cnt == CNT_LAST);
    assign w_load     = tx_start && (!r_busy || w_end);

    assign tx_busy = r_busy && !(w_last_bit && (r_cnt >= CNT_PRE));
    assign txd     = r_txd;
    assign tx_done = r_done;

    // Bit timer and shifter: start bit, 8 data bits, stop bit.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt  <= '0;
            r_bit  <= 4'd0;
            r_sh   <= '1;
            r_busy <= 1'b0;
            r_txd  <= 1'b1;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_busy <= 1'b1;
                r_txd  <= 1'b0;
                r_cnt  <= '0;
                r_bit  <= 4'd0;
                r_sh   <= {1'b1, tx_data};
                r_done <= w_end;
            end else if (r_busy) begin
                if (r_cnt == CNT_LAST) begin
                    r_cnt <= '0;
                    if (w_last_bit) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_txd <= r_sh[0];
                        r_sh  <= {1'b1, r_sh[8:1]};
                        r_bit <= r_bit + 4'd1;
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/adc_frame_uploader.sv
// Drains one channel's capture FIFO after cap_end and sends
// A5 5A CH_ID LEN_HI LEN_LO payload[FRAME_LEN] [CKSUM] over 8N1 UART,
// then re-arms the capture stage through cap_bg.
// Define ADC_UPLOAD_CKSUM_EN to append the 8-bit checksum byte.
// The next payload byte is fetched while the current one is on the wire,
// so consecutive bytes leave back to back.
module adc_frame_uploader
    import adc_upload_pkg::*;
#(
    parameter int         CLK_HZ    = 50_000_000,
    parameter int         BAUD      = 115_200,
    parameter logic [7:0] CH_ID     = 8'h00,
    parameter int         FRAME_LEN = 4096
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       cap_end,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_q,
    output logic       fifo_rdreq,
    output logic       cap_bg,
    output logic       uart_txd,
    output logic       busy,
    output logic       frame_done
);

    localparam int          DIV   = baud_div(CLK_HZ, BAUD);
    localparam logic [15:0] LEN16 = 16'(FRAME_LEN);

    state_t      r_state;
    logic [2:0]  r_hdr_idx;
    logic [15:0] r_payload_cnt;
    logic        r_tx_start;
    logic [7:0]  r_tx_data;
    logic [7:0]  r_byte;
    logic        r_rdreq;
    logic        r_cap_bg;
    logic        r_busy;
    logic        r_frame_done;
    logic        r_drained;
`ifdef ADC_UPLOAD_CKSUM_EN
    logic [7:0]  r_cksum;
`endif

    logic        w_tx_busy;
    logic        w_tx_done;
    logic        w_txd;
    logic        w_tx_ready;
    logic [7:0]  w_hdr_byte;
    logic [15:0] w_cnt_next;

    // A registered start is still in flight for one cycle after it is issued.
    assign w_tx_ready = !w_tx_busy && !r_tx_start;
    assign w_cnt_next = (r_payload_cnt < LEN16) ? (r_payload_cnt + 16'd1) : r_payload_cnt;

    // Header byte selected by position within the header.
    always_comb begin
        w_hdr_byte = 8'h00;
        case (r_hdr_idx)
            3'd0:    w_hdr_byte = SYNC0;
            3'd1:    w_hdr_byte = SYNC1;
            3'd2:    w_hdr_byte = CH_ID;
            3'd3:    w_hdr_byte = LEN16[15:8];
            3'd4:    w_hdr_byte = LEN16[7:0];
            default: w_hdr_byte = 8'h00;
        endcase
    end

    // Frame sequencer: header, payload fetch/send, optional checksum, re-arm.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state       <= ST_IDLE;
            r_hdr_idx     <= 3'd0;
            r_payload_cnt <= 16'd0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_byte        <= 8'h00;
            r_rdreq       <= 1'b0;
            r_cap_bg      <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_drained     <= 1'b0;
`ifdef ADC_UPLOAD_CKSUM_EN
            r_cksum       <= 8'h00;
`endif
        end else begin
            r_tx_start   <= 1'b0;
            r_rdreq      <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cap_end) begin
                        r_busy    <= 1'b1;
                        r_hdr_idx <= 3'd0;
`ifdef ADC_UPLOAD_CKSUM_EN
                        r_cksum   <= 8'h00;
`endif
                        r_state   <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (w_tx_ready) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= w_hdr_byte;
`ifdef ADC_UPLOAD_CKSUM_EN
                        if (r_hdr_idx >= 3'd2) r_cksum <= r_cksum + w_hdr_byte;
`endif
                        if (r_hdr_idx == 3'd4) begin
                            r_payload_cnt <= 16'd0;
                            r_state       <= ST_FETCH;
                        end else begin
                            r_hdr_idx <= r_hdr_idx + 3'd1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (!fifo_empty) begin
                        r_rdreq <= 1'b1;
                        r_state <= ST_WAIT;
                    end else begin
                        r_byte  <= 8'h00;
                        r_state <= ST_SEND;
                    end
                end
                ST_WAIT: begin
                    // fifo_q is valid the cycle after the read pulse.
                    if (!r_rdreq) begin
                        r_byte  <= fifo_q;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_tx_ready) begin
                        r_tx_start    <= 1'b1;
                        r_tx_data     <= r_byte;
                        r_payload_cnt <= w_cnt_next;
`ifdef ADC_UPLOAD_CKSUM_EN
                        r_cksum       <= r_cksum + r_byte;
`endif
                        if (w_cnt_next < LEN16) begin
                            r_state <= ST_FETCH;
                        end else begin
`ifdef ADC_UPLOAD_CKSUM_EN
                            r_state <= ST_CKSUM;
`else
                            r_state <= ST_REARM;
`endif
                        end
                    end
                end
`ifdef ADC_UPLOAD_CKSUM_EN
                ST_CKSUM: begin
                    if (w_tx_ready) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= r_cksum;
                        r_state    <= ST_REARM;
                    end
                end
`endif
                ST_REARM: begin
                    if (!r_drained) begin
                        // Only the byte with no follower ends with the line idle.
                        if (w_tx_done && !w_tx_busy) begin
                            r_frame_done <= 1'b1;
                            r_cap_bg     <= 1'b1;
                            r_drained    <= 1'b1;
                        end
                    end else if (!cap_end) begin
                        r_cap_bg  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_drained <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .DIV(DIV)
    ) u_tx (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .tx_start(r_tx_start),
        .tx_data (r_tx_data),
        .txd     (w_txd),
        .tx_busy (w_tx_busy),
        .tx_done (w_tx_done)
    );

    assign fifo_rdreq = r_rdreq;
    assign cap_bg     = r_cap_bg;
    assign uart_txd   = w_txd;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_adc_frame_uploader.sv
// Testbench for adc_frame_uploader: FIFO model, UART line decoder and a
// frame-level reference model. Honours ADC_UPLOAD_CKSUM_EN when defined.
module tb_adc_frame_uploader;

    localparam int         CLK_HZ = 1_000_000;
    localparam int         BAUD   = 62_500;
    localparam int         BITCLK = CLK_HZ / BAUD;
    localparam logic [7:0] CHID   = 8'h02;
    localparam int         FLEN   = 8;
`ifdef ADC_UPLOAD_CKSUM_EN
    localparam int         FRM    = FLEN + 6;
`else
    localparam int         FRM    = FLEN + 5;
`endif

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b1;
    logic       cap_end = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_q = 8'h00;
    logic       fifo_rdreq, cap_bg, uart_txd, busy, frame_done;

    always #5 Clk = ~Clk;

    adc_frame_uploader #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .CH_ID(CHID), .FRAME_LEN(FLEN)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .cap_end(cap_end), .fifo_empty(fifo_empty),
        .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq), .cap_bg(cap_bg),
        .uart_txd(uart_txd), .busy(busy), .frame_done(frame_done)
    );

    // FIFO model (normal mode: q valid the cycle after rdreq) plus event counters
    logic [7:0] mem [0:63];
    int   wp = 0, rp = 0;
    logic fifo_clr = 1'b0;
    int   rd_cnt = 0, rd_empty_err = 0, fd_cnt = 0, cyc = 0;
    assign fifo_empty = (rp == wp);

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (fifo_clr) rp <= wp;
        else if (fifo_rdreq === 1'b1) begin
            rd_cnt <= rd_cnt + 1;
            if (rp == wp) rd_empty_err <= rd_empty_err + 1;
            else begin
                fifo_q <= mem[rp % 64];
                rp     <= rp + 1;
            end
        end
        if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    end

    // UART decoder: every sample of a bit must match, so misplaced edges show up as glitches
    logic [7:0] rx_byte [0:1023];
    int         rx_t    [0:1023];
    int         rx_n = 0, glitch = 0;

    initial begin : decoder
        int t0;
        bit bad;
        logic [7:0] cur;
        logic bitv;
        forever begin
            @(negedge Clk);
            if (uart_txd === 1'b0) begin
                t0 = cyc; bad = 0; cur = 8'h00; bitv = 1'b0;
                for (int k = 1; k < 10 * BITCLK; k++) begin
                    @(negedge Clk);
                    if (k % BITCLK == 0) bitv = uart_txd;
                    else if (uart_txd !== bitv) bad = 1;
                    if (k / BITCLK >= 1 && k / BITCLK <= 8 && k % BITCLK == BITCLK / 2)
                        cur[k / BITCLK - 1] = uart_txd;
                    if (k / BITCLK == 9 && uart_txd !== 1'b1) bad = 1;
                end
                rx_byte[rx_n % 1024] = cur;
                rx_t[rx_n % 1024]    = t0;
                rx_n = rx_n + 1;
                if (bad) glitch = glitch + 1;
            end
        end
    end

    int n_cmp = 0, n_bad = 0;
    logic [7:0] ld [0:15];
    logic [7:0] exp_q [$];

    // Reference model: the byte sequence a frame must contain for n loaded bytes
    task automatic build_expected(input int n);
        logic [7:0] s, b;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(CHID);
        exp_q.push_back(8'(FLEN / 256));
        exp_q.push_back(8'(FLEN % 256));
        s = CHID + 8'(FLEN / 256) + 8'(FLEN % 256);
        for (int i = 0; i < FLEN; i++) begin
            b = (i < n) ? ld[i] : 8'h00;
            exp_q.push_back(b);
            s = s + b;
        end
`ifdef ADC_UPLOAD_CKSUM_EN
        exp_q.push_back(s);
`endif
    endtask

    task automatic start_frame(input int n);
        @(negedge Clk) fifo_clr = 1'b1;
        @(negedge Clk) fifo_clr = 1'b0;
        for (int i = 0; i < n; i++) mem[(wp + i) % 64] = ld[i];
        wp = wp + n;
        cap_end = 1'b1;
    endtask

    task automatic wait_cap_bg(output bit to);
        to = 1;
        for (int c = 0; c < 30000; c++) begin
            @(negedge Clk);
            if (cap_bg === 1'b1) begin to = 0; break; end
        end
    endtask

    task automatic release_cap(output bit to);
        cap_end = 1'b0;
        to = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            if (busy === 1'b0 && cap_bg === 1'b0) begin to = 0; break; end
        end
    endtask

    task automatic test_reset;
        #1 Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        #1;
        n_cmp++; if (uart_txd !== 1'b1)   begin n_bad++; $display("FAIL rst_txd got %b want 1", uart_txd); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (fifo_rdreq !== 1'b0) begin n_bad++; $display("FAIL rst_rdreq got %b want 0", fifo_rdreq); end
        n_cmp++; if (cap_bg !== 1'b0)     begin n_bad++; $display("FAIL rst_cap_bg got %b want 0", cap_bg); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_frame_done got %b want 0", frame_done); end
        @(negedge Clk) Reset_n = 1'b1;
        repeat (20) @(negedge Clk);
        n_cmp++; if (busy !== 1'b0 || uart_txd !== 1'b1 || rx_n != 0)
            begin n_bad++; $display("FAIL idle_after_rst got busy=%b txd=%b rx=%0d want 0 1 0", busy, uart_txd, rx_n); end
    endtask

    task automatic test_basic;
        int b_rx, b_rd, b_fd, b_gl, gap_bad;
        bit to;
        for (int i = 0; i < FLEN; i++) ld[i] = 8'(i + 1);
        build_expected(FLEN);
        b_rx = rx_n; b_rd = rd_cnt; b_fd = fd_cnt; b_gl = glitch;
        start_frame(FLEN);
        wait_cap_bg(to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL basic_cap_bg got timeout want rise"); end
        release_cap(to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL basic_release got timeout want idle"); end
        repeat (2) @(negedge Clk);
        n_cmp++; if (rx_n - b_rx != FRM) begin n_bad++; $display("FAIL basic_len got %0d want %0d", rx_n - b_rx, FRM); end
        for (int i = 0; i < FRM; i++) begin
            n_cmp++;
            if (rx_byte[(b_rx + i) % 1024] !== exp_q[i])
                begin n_bad++; $display("FAIL basic_byte%0d got %h want %h", i, rx_byte[(b_rx + i) % 1024], exp_q[i]); end
        end
        n_cmp++; if (rd_cnt - b_rd != FLEN) begin n_bad++; $display("FAIL basic_rdreq got %0d want %0d", rd_cnt - b_rd, FLEN); end
        n_cmp++; if (fd_cnt - b_fd != 1) begin n_bad++; $display("FAIL basic_frame_done got %0d want 1", fd_cnt - b_fd); end
        n_cmp++; if (glitch != b_gl) begin n_bad++; $display("FAIL basic_bit_timing got %0d bad bytes want 0", glitch - b_gl); end
        gap_bad = 0;
        for (int i = 1; i < FRM; i++)
            if (rx_t[(b_rx + i) % 1024] - rx_t[(b_rx + i - 1) % 1024] != 10 * BITCLK) gap_bad++;
        n_cmp++; if (gap_bad != 0) begin n_bad++; $display("FAIL basic_start_gap got %0d bad gaps want 0 (gap %0d clk)", gap_bad, 10 * BITCLK); end
    endtask

    task automatic test_random;
        int b_rx, b_rd;
        bit to;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < FLEN; i++) ld[i] = 8'($urandom_range(0, 255));
            build_expected(FLEN);
            b_rx = rx_n; b_rd = rd_cnt;
            start_frame(FLEN);
            wait_cap_bg(to);
            n_cmp++; if (to) begin n_bad++; $display("FAIL rand_cap_bg got timeout want rise"); end
            release_cap(to);
            repeat (2) @(negedge Clk);
            n_cmp++; if (rx_n - b_rx != FRM) begin n_bad++; $display("FAIL rand_len got %0d want %0d", rx_n - b_rx, FRM); end
            for (int i = 0; i < FRM; i++) begin
                n_cmp++;
                if (rx_byte[(b_rx + i) % 1024] !== exp_q[i])
                    begin n_bad++; $display("FAIL rand_byte%0d got %h want %h", i, rx_byte[(b_rx + i) % 1024], exp_q[i]); end
            end
            n_cmp++; if (rd_cnt - b_rd != FLEN) begin n_bad++; $display("FAIL rand_rdreq got %0d want %0d", rd_cnt - b_rd, FLEN); end
        end
    endtask

    task automatic test_underrun;
        int b_rx, b_rd, b_ee;
        bit to;
        for (int i = 0; i < 3; i++) ld[i] = 8'($urandom_range(0, 255));
        build_expected(3);
        b_rx = rx_n; b_rd = rd_cnt; b_ee = rd_empty_err;
        start_frame(3);
        wait_cap_bg(to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL under_cap_bg got timeout want rise"); end
        release_cap(to);
        repeat (2) @(negedge Clk);
        n_cmp++; if (rx_n - b_rx != FRM) begin n_bad++; $display("FAIL under_len got %0d want %0d", rx_n - b_rx, FRM); end
        for (int i = 0; i < FRM; i++) begin
            n_cmp++;
            if (rx_byte[(b_rx + i) % 1024] !== exp_q[i])
                begin n_bad++; $display("FAIL under_byte%0d got %h want %h", i, rx_byte[(b_rx + i) % 1024], exp_q[i]); end
        end
        n_cmp++; if (rd_cnt - b_rd != 3) begin n_bad++; $display("FAIL under_rdreq got %0d want 3", rd_cnt - b_rd); end
        n_cmp++; if (rd_empty_err != b_ee) begin n_bad++; $display("FAIL under_rd_when_empty got %0d want 0", rd_empty_err - b_ee); end
    endtask

    task automatic test_overfill;
        int b_rx, b_rd;
        bit to;
        for (int i = 0; i < 10; i++) ld[i] = 8'($urandom_range(0, 255));
        build_expected(FLEN);
        b_rx = rx_n; b_rd = rd_cnt;
        start_frame(10);
        wait_cap_bg(to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL over_cap_bg got timeout want rise"); end
        n_cmp++; if (rx_n - b_rx != FRM) begin n_bad++; $display("FAIL over_bg_early got %0d bytes want %0d", rx_n - b_rx, FRM); end
        repeat (60) @(negedge Clk);
        n_cmp++; if (cap_bg !== 1'b1 || busy !== 1'b1)
            begin n_bad++; $display("FAIL over_bg_hold got cap_bg=%b busy=%b want 1 1", cap_bg, busy); end
        n_cmp++; if (rd_cnt - b_rd != FLEN) begin n_bad++; $display("FAIL over_rdreq got %0d want %0d", rd_cnt - b_rd, FLEN); end
        release_cap(to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL over_release got cap_bg=%b busy=%b want 0 0", cap_bg, busy); end
        for (int i = 0; i < FRM; i++) begin
            n_cmp++;
            if (rx_byte[(b_rx + i) % 1024] !== exp_q[i])
                begin n_bad++; $display("FAIL over_byte%0d got %h want %h", i, rx_byte[(b_rx + i) % 1024], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid;
        int b_rx, s_rx, s_rd;
        bit to;
        for (int i = 0; i < FLEN; i++) ld[i] = 8'($urandom_range(0, 255));
        b_rx = rx_n;
        start_frame(FLEN);
        to = 1;
        for (int c = 0; c < 10000; c++) begin
            @(negedge Clk);
            if (rx_n >= b_rx + 7) begin to = 0; break; end
        end
        n_cmp++; if (to) begin n_bad++; $display("FAIL mid_reach_byte3 got %0d bytes want 7", rx_n - b_rx); end
        repeat (40) @(negedge Clk);
        #2 Reset_n = 1'b0; cap_end = 1'b0;
        #1;
        n_cmp++; if (uart_txd !== 1'b1)   begin n_bad++; $display("FAIL mid_rst_txd got %b want 1", uart_txd); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        n_cmp++; if (fifo_rdreq !== 1'b0) begin n_bad++; $display("FAIL mid_rst_rdreq got %b want 0", fifo_rdreq); end
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (200) @(negedge Clk);
        s_rx = rx_n; s_rd = rd_cnt;
        repeat (400) @(negedge Clk);
        n_cmp++; if (rx_n != s_rx || rd_cnt != s_rd || busy !== 1'b0 || uart_txd !== 1'b1)
            begin n_bad++; $display("FAIL mid_quiet got rx+%0d rd+%0d busy=%b txd=%b want 0 0 0 1", rx_n - s_rx, rd_cnt - s_rd, busy, uart_txd); end
    endtask

    task automatic test_after_reset;
        int b_rx, b_fd, b_gl;
        bit to;
        for (int i = 0; i < FLEN; i++) ld[i] = 8'($urandom_range(0, 255));
        build_expected(FLEN);
        b_rx = rx_n; b_fd = fd_cnt; b_gl = glitch;
        start_frame(FLEN);
        wait_cap_bg(to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL after_cap_bg got timeout want rise"); end
        release_cap(to);
        repeat (2) @(negedge Clk);
        n_cmp++; if (rx_n - b_rx != FRM) begin n_bad++; $display("FAIL after_len got %0d want %0d", rx_n - b_rx, FRM); end
        for (int i = 0; i < FRM; i++) begin
            n_cmp++;
            if (rx_byte[(b_rx + i) % 1024] !== exp_q[i])
                begin n_bad++; $display("FAIL after_byte%0d got %h want %h", i, rx_byte[(b_rx + i) % 1024], exp_q[i]); end
        end
        n_cmp++; if (fd_cnt - b_fd != 1) begin n_bad++; $display("FAIL after_frame_done got %0d want 1", fd_cnt - b_fd); end
        n_cmp++; if (glitch != b_gl) begin n_bad++; $display("FAIL after_bit_timing got %0d bad bytes want 0", glitch - b_gl); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_random;
        test_underrun;
        test_overfill;
        test_reset_mid;
        test_after_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
